// File: rtl/sfr_pack_wait.sv
// sfr_pack_wait
// CPU-visible special function register file on the packed memory bus.
// Provides N_REGS 32-bit registers. Writes can be byte-masked word writes
// or single-bit set/clear/toggle operations, and per-bit write masks
// protect read-only bits. Reads return the externally supplied sfRegsIn
// value after a programmable number of wait states, and pulse a per-register
// read strobe so the host peripheral can implement side-effecting reads.
//
// Ports
//   clk             clock
//   rst_n           synchronous reset, active low
//   sfRegsOut       stored register bits, N_REGS*32
//   sfRegsWrStr     1-cycle pulse on every bit actually written
//   sfRegsRdStr     1-cycle pulse per register read, coincident with ack
//   sfRegsIn        read-back value, sampled when a read completes
//   mem_packed_fwd  {mem_valid, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]}
//   mem_packed_ret  {mem_ready, mem_rdata[31:0]}
//
// Address map: [31:24] BASE_ADDR, [23:16] BASE2_ADDR, [15:14] must be 0,
// [13:9] register in bit mode, [8:7] mode (0 word, 1 set, 2 clear,
// 3 toggle), [6:2] register in word mode / bit index in bit mode.
module sfr_pack_wait #(
    parameter logic [7:0]            BASE_ADDR     = 8'h00,
    parameter logic [7:0]            BASE2_ADDR    = 8'h00,
    parameter int                    N_REGS        = 1,
    parameter logic [N_REGS*32-1:0]  INITIAL_STATE = '0,
    parameter logic [N_REGS*32-1:0]  WR_MASK       = '1,
    parameter int                    RD_WAIT       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [N_REGS*32-1:0]   sfRegsOut,
    output logic [N_REGS*32-1:0]   sfRegsWrStr,
    output logic [N_REGS-1:0]      sfRegsRdStr,
    input  logic [N_REGS*32-1:0]   sfRegsIn,
    input  logic [68:0]            mem_packed_fwd,
    output logic [32:0]            mem_packed_ret
);

    typedef enum logic {IDLE, WAIT_RD} state_t;

    // Counter preload: the accepting edge is one of the RD_WAIT+1 cycles.
    localparam logic [3:0]  WAIT_INIT = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;
    localparam logic [15:0] MATCH     = {BASE_ADDR, BASE2_ADDR};

    // Bus fields
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;

    assign {mem_valid, mem_addr, mem_wdata, mem_wstrb} = mem_packed_fwd;

    // Word-aligned bus: the byte offset carries no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[1:0];

    // State
    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic                   ready_q;
    logic [31:0]            rdata_q;
    logic [N_REGS*32-1:0]   regs_q;
    logic [N_REGS*32-1:0]   wr_str_q;
    logic [N_REGS-1:0]      rd_str_q;
    logic [4:0]             lat_reg_q;
    logic [4:0]             lat_bit_q;
    logic                   lat_bitmode_q;

    logic [N_REGS*32-1:0]   regs_d;
    logic [N_REGS*32-1:0]   wr_str_d;
    logic [N_REGS-1:0]      rd_str_d;

    assign sfRegsOut      = regs_q;
    assign sfRegsWrStr    = wr_str_q;
    assign sfRegsRdStr    = rd_str_q;
    assign mem_packed_ret = {ready_q, rdata_q};

    // Decode. ready_q blocks re-accepting the transfer just acknowledged.
    logic        hit;
    logic [1:0]  acc_mode;
    logic        acc_bitmode;
    logic [4:0]  acc_reg;
    logic [4:0]  acc_bit;
    logic        is_write;
    logic        wr_en;
    logic [31:0] byte_en;
    logic [31:0] bit_onehot;

    assign hit         = (state_q == IDLE) && mem_valid && !ready_q &&
                         (mem_addr[31:16] == MATCH) && (mem_addr[15:14] == 2'b00);
    assign acc_mode    = mem_addr[8:7];
    assign acc_bitmode = |acc_mode;
    assign acc_reg     = acc_bitmode ? mem_addr[13:9] : mem_addr[6:2];
    assign acc_bit     = mem_addr[6:2];
    assign is_write    = |mem_wstrb;
    assign wr_en       = hit && is_write;
    assign byte_en     = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                          {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign bit_onehot  = 32'd1 << acc_bit;

    // Read completion: immediately when there are no wait states, otherwise
    // when the countdown expires while the master is still requesting.
    logic rd_now;
    logic wait_done;
    logic rd_done;

    assign rd_now    = hit && !is_write && (RD_WAIT == 0);
    assign wait_done = (state_q == WAIT_RD) && mem_valid && (cnt_q == 4'd0);
    assign rd_done   = rd_now || wait_done;

    // In WAIT the address may still be on the bus, but the latched copy is
    // authoritative for which register is being read.
    logic [4:0] rd_reg;
    logic [4:0] rd_bit;
    logic       rd_bitmode;

    assign rd_reg     = (state_q == WAIT_RD) ? lat_reg_q     : acc_reg;
    assign rd_bit     = (state_q == WAIT_RD) ? lat_bit_q     : acc_bit;
    assign rd_bitmode = (state_q == WAIT_RD) ? lat_bitmode_q : acc_bitmode;

    // Per-register write and read-strobe logic. Out-of-range indices match
    // no instance, so they naturally produce no write and no strobe.
    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_reg
            localparam logic [31:0] MASK = WR_MASK[gi*32 +: 32];

            logic        sel;
            logic [31:0] cur;
            logic [31:0] str;
            logic [31:0] nxt;

            assign cur = regs_q[gi*32 +: 32];
            assign sel = wr_en && (acc_reg == 5'(gi));
            assign str = sel ? ((acc_bitmode ? bit_onehot : byte_en) & MASK) : 32'd0;

            always_comb begin
                case (acc_mode)
                    2'd0:    nxt = (cur & ~str) | (mem_wdata & str);
                    2'd1:    nxt = cur | str;
                    2'd2:    nxt = cur & ~str;
                    default: nxt = cur ^ str;
                endcase
            end

            assign regs_d[gi*32 +: 32]   = nxt;
            assign wr_str_d[gi*32 +: 32] = str;
            assign rd_str_d[gi]          = rd_done && (rd_reg == 5'(gi));
        end
    endgenerate

    // Read data mux; out-of-range registers read as zero. In bit mode the
    // returned bit is taken from the addressed register's read-back word.
    logic [31:0] rd_word;
    logic [31:0] rd_data;

    always_comb begin
        rd_word = 32'd0;
        for (int r = 0; r < N_REGS; r++) begin
            if (rd_reg == 5'(r)) begin
                rd_word = sfRegsIn[r*32 +: 32];
            end
        end
        rd_data = rd_bitmode ? {31'd0, rd_word[rd_bit]} : rd_word;
    end

    // Bus FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            ready_q       <= 1'b0;
            rdata_q       <= 32'd0;
            regs_q        <= INITIAL_STATE;
            wr_str_q      <= '0;
            rd_str_q      <= '0;
            lat_reg_q     <= 5'd0;
            lat_bit_q     <= 5'd0;
            lat_bitmode_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            wr_str_q <= wr_str_d;
            rd_str_q <= rd_str_d;
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;

            case (state_q)
                IDLE: begin
                    if (hit) begin
                        if (is_write || RD_WAIT == 0) begin
                            ready_q <= 1'b1;
                            rdata_q <= is_write ? 32'd0 : rd_data;
                        end else begin
                            lat_reg_q     <= acc_reg;
                            lat_bit_q     <= acc_bit;
                            lat_bitmode_q <= acc_bitmode;
                            cnt_q         <= WAIT_INIT;
                            state_q       <= WAIT_RD;
                        end
                    end
                end
                default: begin
                    // Master gave up: abandon the read silently.
                    if (!mem_valid) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        ready_q <= 1'b1;
                        rdata_q <= rd_data;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule
